// File: rtl/branch_offset_enc.sv
// -----------------------------------------------------------------------------
// branch_offset_enc
//
// Converts an absolute branch target into the ARM B/BL 24-bit word offset and
// a complete branch instruction word. This is the inverse of the branch
// extender. It runs as a two-stage valid/ready pipeline that accepts one
// request per cycle:
//   stage 1 : diff = target - (pc + PC_AHEAD), modulo 2^32
//   stage 2 : alignment/range checks and the encoded result (output register)
// A saturating counter tracks how many erroneous results were delivered.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  request accepted this cycle
//   pc         in   [31:0] address of the branch instruction
//   target     in   [31:0] branch destination address
//   cond       in   [3:0]  condition field
//   link       in   1 = BL, 0 = B
//   out_valid  out  result present
//   out_ready  in   consumer accepts result
//   instr      out  [31:0] encoded instruction (0 on error)
//   offset     out  [23:0] encoded offset field (0 on error)
//   err_align  out  difference not word aligned
//   err_range  out  difference outside the branch range
//   err_count  out  [ERR_CNT_W-1:0] erroneous results delivered, saturating
// -----------------------------------------------------------------------------
module branch_offset_enc #(
    parameter int PC_AHEAD  = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          pc,
    input  logic [31:0]          target,
    input  logic [3:0]           cond,
    input  logic                 link,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic [23:0]          offset,
    output logic                 err_align,
    output logic                 err_range,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [31:0] PC_AHEAD_C = 32'(PC_AHEAD);

    // A branch reaches +/-32 MiB: the top seven bits of the difference must
    // be pure sign extension of bit 25.
    function automatic logic in_range(input logic [31:0] d);
        return (d[31:25] == 7'h00) || (d[31:25] == 7'h7F);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Control
    logic                 vld_p1_q, vld_p1_d;
    logic                 vld_p2_q, vld_p2_d;
    logic                 s1_adv, s2_adv;
    logic                 in_fire, out_fire, ld_p2;

    // Stage-1 data (no reset needed: only consumed when vld_p1_q is set)
    logic signed [31:0]   diff_p1_q;
    logic [3:0]           cond_p1_q;
    logic                 link_p1_q;

    // Stage-2 / output registers
    logic [31:0]          instr_p2_q, instr_d;
    logic [23:0]          offset_p2_q, offset_d;
    logic                 ea_p2_q, ea_d;
    logic                 er_p2_q, er_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Stage 2 can take new data when it is empty or being drained this
    // cycle; stage 1 likewise when it is empty or moving into stage 2.
    always_comb begin
        s2_adv   = !vld_p2_q || out_ready;
        s1_adv   = !vld_p1_q || s2_adv;
        in_fire  = in_valid && s1_adv;
        out_fire = vld_p2_q && out_ready;
        ld_p2    = vld_p1_q && s2_adv;
        vld_p1_d = s1_adv ? in_valid : vld_p1_q;
        vld_p2_d = s2_adv ? vld_p1_q : vld_p2_q;
    end

    // ---- stage 0 -> stage 1 : difference against the prefetched pc ----
    always_ff @(posedge clk) begin
        if (in_fire) begin
            diff_p1_q <= target - (pc + PC_AHEAD_C);
            cond_p1_q <= cond;
            link_p1_q <= link;
        end
    end

    // ---- stage 1 -> stage 2 : checks and encoding ----
    always_comb begin
        ea_d     = |diff_p1_q[1:0];
        er_d     = !in_range(diff_p1_q);
        offset_d = '0;
        instr_d  = '0;
        if (!ea_d && !er_d) begin
            offset_d = diff_p1_q[25:2];
            instr_d  = {cond_p1_q, 3'b101, link_p1_q, diff_p1_q[25:2]};
        end
    end

    // Only results actually handed to the consumer are counted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_fire && (ea_p2_q || er_p2_q)) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            instr_p2_q  <= '0;
            offset_p2_q <= '0;
            ea_p2_q     <= 1'b0;
            er_p2_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            err_cnt_q <= err_cnt_d;
            // Result fields only change when stage 2 loads, so they hold
            // steady while the consumer stalls.
            if (ld_p2) begin
                instr_p2_q  <= instr_d;
                offset_p2_q <= offset_d;
                ea_p2_q     <= ea_d;
                er_p2_q     <= er_d;
            end
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = vld_p2_q;
    assign instr     = instr_p2_q;
    assign offset    = offset_p2_q;
    assign err_align = ea_p2_q;
    assign err_range = er_p2_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_branch_offset_enc.sv
// -----------------------------------------------------------------------------
// tb_branch_offset_enc
//
// Self-checking bench for branch_offset_enc. Requests are pushed into an
// expectation queue (computed with plain integer arithmetic) when the input
// handshake occurs, and popped and compared when the output handshake occurs.
// -----------------------------------------------------------------------------
module tb_branch_offset_enc;

    localparam int PC_AHEAD  = 8;
    localparam int ERR_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          pc;
    logic [31:0]          target;
    logic [3:0]           cond;
    logic                 link;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [31:0]          instr;
    logic [23:0]          offset;
    logic                 err_align;
    logic                 err_range;
    logic [ERR_CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    branch_offset_enc #(
        .PC_AHEAD  (PC_AHEAD),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc        (pc),
        .target    (target),
        .cond      (cond),
        .link      (link),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .offset    (offset),
        .err_align (err_align),
        .err_range (err_range),
        .err_count (err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] instr;
        logic [23:0] off;
        bit          ea;
        bit          er;
    } exp_t;

    // Reference: signed word distance from the prefetched pc, legal when it
    // is a multiple of 4 and lies within [-2^25, 2^25-1].
    function automatic exp_t model(input logic [31:0] p, input logic [31:0] t,
                                   input logic [3:0] c, input logic l);
        exp_t e;
        int   d;
        d     = $signed(t - p - 32'(PC_AHEAD));
        e.pc  = p;
        e.tgt = t;
        e.ea  = (d % 4) != 0;
        e.er  = (d < -(1 << 25)) || (d > (1 << 25) - 1);
        if (e.ea || e.er) begin
            e.off   = '0;
            e.instr = '0;
        end else begin
            e.off   = 24'(d / 4);
            e.instr = (32'(c) << 28) | 32'h0A00_0000 | (32'(l) << 24) | 32'(e.off);
        end
        return e;
    endfunction

    exp_t        exp_q[$];
    int          exp_cnt   = 0;
    int          n_out     = 0;
    int          stall_cnt = 0;
    bit          held      = 0;
    logic [31:0] h_instr;
    logic [23:0] h_off;
    logic        h_ea, h_er;

    bit   bp_en    = 0;
    logic or_force = 1'b1;

    always @(posedge clk) begin
        #2;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : or_force;
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] rt;
        if (reset_n) begin
            check("err_count", 32'(err_count), 32'(exp_cnt));
            if (held && out_valid) begin
                check("hold_instr",  instr, h_instr);
                check("hold_offset", 32'(offset), 32'(h_off));
                check("hold_flags",  32'({err_align, err_range}), 32'({h_ea, h_er}));
            end
            held    = out_valid && !out_ready;
            h_instr = instr;
            h_off   = offset;
            h_ea    = err_align;
            h_er    = err_range;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("stale_output", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("instr",     instr, e.instr);
                    check("offset",    32'(offset), 32'(e.off));
                    check("err_align", 32'(err_align), 32'(e.ea));
                    check("err_range", 32'(err_range), 32'(e.er));
                    if (!e.ea && !e.er) begin
                        rt = e.pc + 32'(PC_AHEAD) + ({{8{offset[23]}}, offset} << 2);
                        check("round_trip", rt, e.tgt);
                    end
                    if ((e.ea || e.er) && exp_cnt < CNT_MAX) exp_cnt++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(pc, target, cond, link));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    // with in_valid still high so requests can stream back to back.
    task automatic send(input logic [31:0] p, input logic [31:0] t,
                        input logic [3:0] c, input logic l);
        bit acc = 0;
        int n   = 0;
        pc = p; target = t; cond = c; link = l; in_valid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stall_cnt++;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic directed(input string tag, input logic [31:0] p, input logic [31:0] t,
                            input logic [3:0] c, input logic l, input logic [31:0] x_instr,
                            input logic [23:0] x_off, input logic x_ea, input logic x_er);
        send(p, t, c, l);
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        check({tag, "_lat2"},  32'(out_valid), 32'(1));
        check({tag, "_instr"}, instr, x_instr);
        check({tag, "_off"},   32'(offset), 32'(x_off));
        check({tag, "_flags"}, 32'({err_align, err_range}), 32'({x_ea, x_er}));
        drain();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p, t, d;
        int          out0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        pc = '0; target = '0; cond = '0; link = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_instr",     instr, 32'(0));
        check("rst_offset",    32'(offset), 32'(0));
        check("rst_flags",     32'({err_align, err_range}), 32'(0));
        check("rst_err_count", 32'(err_count), 32'(0));
        check("rst_in_ready",  32'(in_ready), 32'(1));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Forward / backward / link
        directed("fwd",  32'h1000, 32'h1010, 4'hE, 1'b0, 32'hEA00_0002, 24'h000002, 1'b0, 1'b0);
        directed("self", 32'h1000, 32'h1000, 4'hE, 1'b0, 32'hEAFF_FFFE, 24'hFFFFFE, 1'b0, 1'b0);
        directed("bl",   32'h1000, 32'h1008, 4'hE, 1'b1, 32'hEB00_0000, 24'h000000, 1'b0, 1'b0);
        directed("wrap", 32'hFFFF_FFF8, 32'h0000_0004, 4'h0, 1'b0, 32'h0A00_0001, 24'h000001, 1'b0, 1'b0);

        // Alignment error and first counter step
        check("cnt_before_align", 32'(err_count), 32'(0));
        directed("align", 32'h1000, 32'h1012, 4'hE, 1'b0, 32'h0, 24'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("cnt_after_align", 32'(err_count), 32'(1));

        // Range limits from pc = 0
        directed("rng_pmax", 32'h0, 32'h0200_0004, 4'hE, 1'b0, 32'hEA7F_FFFF, 24'h7FFFFF, 1'b0, 1'b0);
        directed("rng_pbad", 32'h0, 32'h0200_0008, 4'hE, 1'b0, 32'h0, 24'h0, 1'b0, 1'b1);
        directed("rng_nmax", 32'h0, 32'hFE00_0008, 4'hE, 1'b0, 32'hEA80_0000, 24'h800000, 1'b0, 1'b0);
        directed("rng_nbad", 32'h0, 32'hFE00_0004, 4'hE, 1'b0, 32'h0, 24'h0, 1'b0, 1'b1);
        directed("both",     32'h0, 32'h4000_000B, 4'hE, 1'b0, 32'h0, 24'h0, 1'b1, 1'b1);

        // Counter saturation: 300 misaligned branches streamed back to back
        for (int i = 0; i < 300; i++) begin
            p = $urandom;
            send(p, p + 32'(PC_AHEAD) + ($urandom_range(0, 4095) << 2) + 32'($urandom_range(1, 3)),
                 4'($urandom), 1'($urandom));
        end
        drain();
        @(posedge clk); #1;
        check("cnt_saturated", 32'(err_count), 32'(CNT_MAX));

        // Backpressure: two accepted, then the pipe is full
        or_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out0 = n_out;
        send(32'h2000, 32'h2100, 4'h1, 1'b0);
        send(32'h2000, 32'h1F00, 4'h2, 1'b1);
        pc = 32'h3000; target = 32'h3008; cond = 4'h3; link = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready",  32'(in_ready), 32'(0));
            check("bp_out_valid", 32'(out_valid), 32'(1));
        end
        @(posedge clk); #1;
        or_force = 1'b1;
        send(32'h3000, 32'h3008, 4'h3, 1'b0);
        send(32'h4000, 32'h0, 4'h4, 1'b1);
        drain();
        check("bp_delivered", 32'(n_out - out0), 32'(4));

        // Full-throughput random round trips: legal aligned differences only
        stall_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            p = $urandom;
            d = {{8{1'b0}}, 24'($urandom)};
            d = {{8{d[23]}}, d[23:0]} << 2;
            send(p, p + 32'(PC_AHEAD) + d, 4'($urandom), 1'($urandom));
        end
        drain();
        check("no_bubble_stalls", 32'(stall_cnt), 32'(0));

        // Mixed random traffic under random backpressure
        bp_en = 1;
        for (int i = 0; i < 200; i++) begin
            p = $urandom;
            t = ($urandom_range(0, 1) == 1) ? $urandom
                                            : p + 32'(PC_AHEAD) + (32'($signed(14'($urandom))) << 2);
            send(p, t, 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        drain();
        bp_en = 0;
        or_force = 1'b1;

        // Reset with both stages full
        or_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(32'h5000, 32'h5010, 4'hE, 1'b0);
        send(32'h5000, 32'h5011, 4'hE, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_err_count", 32'(err_count), 32'(0));
        check("mid_rst_instr",     instr, 32'(0));
        exp_q.delete();
        exp_cnt = 0;
        held    = 0;
        or_force = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        out0 = n_out;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_output", 32'(n_out - out0), 32'(0));
        check("post_rst_err_count", 32'(err_count), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
